// File: rtl/decode_pipe.sv
// Decode stage: instruction field extraction, register file read, immediate generation and
// an ID/EX output register with load-use hazard stalling and flush.
module decode_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pcplus4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_opcode,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pcplus4,
    output logic            out_is_load,
    output logic            out_bad_reg,
    output logic [15:0]     stall_cnt
);

    localparam int unsigned RW     = $clog2(NREGS);
    localparam logic [5:0]  NREGS6 = 6'(NREGS);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            use_rs1, use_rs2, writes_rd;
    logic            hazard, accept, bad_reg;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x, rdata1, rdata2;
    logic [RW-1:0]   ridx1, ridx2, widx;

    always_comb begin
        opcode    = in_instr[6:0];
        rs1       = in_instr[19:15];
        rs2       = in_instr[24:20];
        rd        = in_instr[11:7];
        use_rs1   = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        use_rs2   = opcode inside {OP_R, OP_S, OP_B};
        writes_rd = !(opcode inside {OP_S, OP_B});
        hazard    = out_valid & out_is_load & (out_rd != 5'd0) &
                    ((use_rs1 & (rs1 == out_rd)) | (use_rs2 & (rs2 == out_rd)));
        in_ready  = ~flush & ~hazard & (~out_valid | out_ready);
        accept    = in_valid & in_ready;
        bad_reg   = (use_rs1 & ({1'b0, rs1} >= NREGS6)) |
                    (use_rs2 & ({1'b0, rs2} >= NREGS6)) |
                    (writes_rd & ({1'b0, rd} >= NREGS6));
    end

    always_comb begin
        imm32 = 32'd0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_B:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {in_instr[31:12], 12'd0};
            OP_JAL: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        imm_x = XLEN'(signed'(imm32));
    end

    // Register file is indexed by the low RW bits; x0 is hardwired to zero.
    always_comb begin
        ridx1 = rs1[RW-1:0];
        ridx2 = rs2[RW-1:0];
        widx  = wb_rd[RW-1:0];
        if (ridx1 == '0) rdata1 = '0;
        else if (BYPASS && wb_we && (widx == ridx1)) rdata1 = wb_data;
        else rdata1 = regs[ridx1];
        if (ridx2 == '0) rdata2 = '0;
        else if (BYPASS && wb_we && (widx == ridx2)) rdata2 = wb_data;
        else rdata2 = regs[ridx2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (wb_we && (widx != '0)) begin
            regs[widx] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_opcode  <= '0;
            out_rd1     <= '0;
            out_rd2     <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_pcplus4 <= '0;
            out_is_load <= 1'b0;
            out_bad_reg <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_rs1     <= rs1;
            out_rs2     <= rs2;
            out_rd      <= rd;
            out_funct3  <= in_instr[14:12];
            out_opcode  <= opcode;
            out_rd1     <= rdata1;
            out_rd2     <= rdata2;
            out_imm     <= imm_x;
            out_pc      <= in_pc;
            out_pcplus4 <= in_pcplus4;
            out_is_load <= (opcode == OP_LOAD);
            out_bad_reg <= bad_reg;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (in_valid && hazard && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: a default instance plus an XLEN=64, NREGS=16, BYPASS=0
// instance sharing the same stimulus.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, flush, out_ready, wb_we;
    logic [31:0] in_instr;
    logic [63:0] in_pc, in_pcplus4, wb_data;
    logic [4:0]  wb_rd;

    logic        a_in_ready, a_out_valid, a_out_is_load, a_out_bad_reg;
    logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
    logic [2:0]  a_out_funct3;
    logic [6:0]  a_out_opcode;
    logic [31:0] a_out_rd1, a_out_rd2, a_out_imm, a_out_pc, a_out_pcplus4;
    logic [15:0] a_stall_cnt;

    logic        b_in_ready, b_out_valid, b_out_is_load, b_out_bad_reg;
    logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
    logic [2:0]  b_out_funct3;
    logic [6:0]  b_out_opcode;
    logic [63:0] b_out_rd1, b_out_rd2, b_out_imm, b_out_pc, b_out_pcplus4;
    logic [15:0] b_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_pcplus4(in_pcplus4[31:0]),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_rs1(a_out_rs1),
        .out_rs2(a_out_rs2), .out_rd(a_out_rd), .out_funct3(a_out_funct3),
        .out_opcode(a_out_opcode), .out_rd1(a_out_rd1), .out_rd2(a_out_rd2),
        .out_imm(a_out_imm), .out_pc(a_out_pc), .out_pcplus4(a_out_pcplus4),
        .out_is_load(a_out_is_load), .out_bad_reg(a_out_bad_reg), .stall_cnt(a_stall_cnt)
    );

    decode_pipe #(.XLEN(64), .NREGS(16), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_rs1(b_out_rs1),
        .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_funct3(b_out_funct3),
        .out_opcode(b_out_opcode), .out_rd1(b_out_rd1), .out_rd2(b_out_rd2),
        .out_imm(b_out_imm), .out_pc(b_out_pc), .out_pcplus4(b_out_pcplus4),
        .out_is_load(b_out_is_load), .out_bad_reg(b_out_bad_reg), .stall_cnt(b_stall_cnt)
    );

    localparam logic [31:0] I_ADDI_6_5_1 = 32'h0012_8313;
    localparam logic [31:0] I_LW_7_1     = 32'h0000_A383;
    localparam logic [31:0] I_ADD_8_7_2  = 32'h0023_8433;
    localparam logic [31:0] I_ADD_4_3_0  = 32'h0001_8233;
    localparam logic [31:0] I_SW_2_M4_1  = 32'hFE20_AE23;
    localparam logic [31:0] I_BEQ_1_2_8  = 32'h0020_8463;
    localparam logic [31:0] I_JAL_1_M2   = 32'hFFFF_F0EF;
    localparam logic [31:0] I_LW_8_1     = 32'h0000_A403;
    localparam logic [31:0] I_LUI_1      = 32'h1234_50B7;
    localparam logic [31:0] I_ADDI_1_0_0 = 32'h0000_0093;
    localparam logic [31:0] I_ADDI_1_20  = 32'h000A_0093;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pcplus4 = '0;
        flush = 1'b0; out_ready = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %0h want 0", a_out_valid); end
        n_cmp++; if (a_stall_cnt !== 16'd0) begin n_err++;
            $display("FAIL reset_stall: got %0h want 0", a_stall_cnt); end
        n_cmp++; if (b_out_imm !== 64'd0) begin n_err++;
            $display("FAIL reset_imm: got %0h want 0", b_out_imm); end
        reset = 1'b0;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready: got %0h want 1", a_in_ready); end
    endtask

    task automatic test_basic();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        tick();
        wb_we = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_ADDI_6_5_1; in_pc = 64'h100; in_pcplus4 = 64'h104;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
            $display("FAIL basic_ready: got %0h want 1", a_in_ready); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b1) begin n_err++;
            $display("FAIL basic_valid: got %0h want 1", a_out_valid); end
        n_cmp++; if (a_out_rd1 !== 32'h1234) begin n_err++;
            $display("FAIL basic_rd1: got %0h want 1234", a_out_rd1); end
        n_cmp++; if (a_out_imm !== 32'd1) begin n_err++;
            $display("FAIL basic_imm: got %0h want 1", a_out_imm); end
        n_cmp++; if (a_out_rd !== 5'd6 || a_out_rs1 !== 5'd5) begin n_err++;
            $display("FAIL basic_regs: got rd=%0d rs1=%0d want 6 5", a_out_rd, a_out_rs1); end
        n_cmp++; if (a_out_pc !== 32'h100 || a_out_pcplus4 !== 32'h104) begin n_err++;
            $display("FAIL basic_pc: got %0h %0h want 100 104", a_out_pc, a_out_pcplus4); end
        n_cmp++; if (b_out_rd1 !== 64'h1234) begin n_err++;
            $display("FAIL basic_rd1_b: got %0h want 1234", b_out_rd1); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++;
            $display("FAIL basic_bubble: got %0h want 0", a_out_valid); end
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instr = I_LW_7_1;
        tick();
        n_cmp++; if (a_out_is_load !== 1'b1 || a_out_rd !== 5'd7) begin n_err++;
            $display("FAIL lu_load: got ld=%0h rd=%0d want 1 7", a_out_is_load, a_out_rd); end
        in_instr = I_ADD_8_7_2;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++;
            $display("FAIL lu_stall_ready: got %0h want 0", a_in_ready); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++;
            $display("FAIL lu_bubble: got %0h want 0", a_out_valid); end
        n_cmp++; if (a_stall_cnt !== 16'd1) begin n_err++;
            $display("FAIL lu_stall_cnt: got %0d want 1", a_stall_cnt); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
            $display("FAIL lu_ready_after: got %0h want 1", a_in_ready); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd8) begin n_err++;
            $display("FAIL lu_add: got v=%0h rd=%0d want 1 8", a_out_valid, a_out_rd); end
        n_cmp++; if (a_out_rs1 !== 5'd7 || a_out_rs2 !== 5'd2 || a_out_is_load !== 1'b0)
        begin n_err++;
            $display("FAIL lu_add_fields: got rs1=%0d rs2=%0d ld=%0h want 7 2 0",
                     a_out_rs1, a_out_rs2, a_out_is_load); end
        n_cmp++; if (a_stall_cnt !== 16'd1) begin n_err++;
            $display("FAIL lu_stall_hold: got %0d want 1", a_stall_cnt); end
    endtask

    task automatic test_bypass();
        in_instr = I_ADD_4_3_0;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 64'hDEAD;
        tick();
        wb_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (a_out_rd1 !== 32'hDEAD) begin n_err++;
            $display("FAIL bypass_on: got %0h want dead", a_out_rd1); end
        n_cmp++; if (b_out_rd1 !== 64'd0) begin n_err++;
            $display("FAIL bypass_off: got %0h want 0", b_out_rd1); end
        n_cmp++; if (a_out_rd2 !== 32'd0) begin n_err++;
            $display("FAIL bypass_x0: got %0h want 0", a_out_rd2); end
    endtask

    task automatic test_backpressure_flush();
        in_valid = 1'b1; in_instr = I_SW_2_M4_1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (a_in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_ready[%0d]: got %0h want 0", i, a_in_ready); end
            tick();
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd4 || a_out_rd1 !== 32'hDEAD)
            begin n_err++;
                $display("FAIL bp_hold[%0d]: got v=%0h rd=%0d rd1=%0h want 1 4 dead",
                         i, a_out_valid, a_out_rd, a_out_rd1); end
        end
        flush = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_ready: got %0h want 0", a_in_ready); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++;
            $display("FAIL flush_valid: got %0h want 0", a_out_valid); end
        flush = 1'b0;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_ready_after: got %0h want 1", a_in_ready); end
    endtask

    task automatic test_imm_types();
        out_ready = 1'b1;
        tick();
        n_cmp++; if (a_out_imm !== 32'hFFFF_FFFC || a_out_funct3 !== 3'd2 ||
                     a_out_opcode !== 7'h23) begin n_err++;
            $display("FAIL s_imm: got imm=%0h f3=%0d op=%0h want fffffffc 2 23",
                     a_out_imm, a_out_funct3, a_out_opcode); end
        n_cmp++; if (b_out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++;
            $display("FAIL s_imm_64: got %0h want fffffffffffffffc", b_out_imm); end
        in_instr = I_BEQ_1_2_8;
        tick();
        n_cmp++; if (a_out_imm !== 32'd8 || a_out_rs2 !== 5'd2) begin n_err++;
            $display("FAIL b_imm: got imm=%0h rs2=%0d want 8 2", a_out_imm, a_out_rs2); end
        in_instr = I_JAL_1_M2;
        tick();
        n_cmp++; if (a_out_imm !== 32'hFFFF_FFFE || a_out_rd !== 5'd1) begin n_err++;
            $display("FAIL j_imm: got imm=%0h rd=%0d want fffffffe 1", a_out_imm, a_out_rd); end
        n_cmp++; if (b_out_imm !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++;
            $display("FAIL j_imm_64: got %0h want fffffffffffffffe", b_out_imm); end
        in_instr = I_LW_8_1;
        tick();
        in_instr = I_LUI_1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
            $display("FAIL lui_nostall: got %0h want 1", a_in_ready); end
        tick();
        n_cmp++; if (a_out_imm !== 32'h1234_5000 || a_out_rd !== 5'd1 || a_stall_cnt !== 16'd1)
        begin n_err++;
            $display("FAIL lui_imm: got imm=%0h rd=%0d st=%0d want 12345000 1 1",
                     a_out_imm, a_out_rd, a_stall_cnt); end
        n_cmp++; if (b_out_imm !== 64'h0000_0000_1234_5000) begin n_err++;
            $display("FAIL lui_imm_64: got %0h want 12345000", b_out_imm); end
    endtask

    task automatic test_bad_reg_x0();
        in_instr = I_ADDI_1_0_0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
        tick();
        wb_we = 1'b0;
        n_cmp++; if (a_out_rd1 !== 32'd0 || b_out_rd1 !== 64'd0) begin n_err++;
            $display("FAIL x0_bypass: got %0h %0h want 0 0", a_out_rd1, b_out_rd1); end
        tick();
        n_cmp++; if (a_out_rd1 !== 32'd0 || b_out_rd1 !== 64'd0) begin n_err++;
            $display("FAIL x0_read: got %0h %0h want 0 0", a_out_rd1, b_out_rd1); end
        in_instr = I_ADDI_1_20;
        tick();
        n_cmp++; if (b_out_bad_reg !== 1'b1 || b_out_rs1 !== 5'd20) begin n_err++;
            $display("FAIL bad_reg16: got bad=%0h rs1=%0d want 1 20", b_out_bad_reg, b_out_rs1); end
        n_cmp++; if (a_out_bad_reg !== 1'b0) begin n_err++;
            $display("FAIL bad_reg32: got %0h want 0", a_out_bad_reg); end
        in_instr = I_ADDI_6_5_1;
        tick();
        n_cmp++; if (b_out_bad_reg !== 1'b0 || b_out_rd1 !== 64'h1234) begin n_err++;
            $display("FAIL good_reg16: got bad=%0h rd1=%0h want 0 1234", b_out_bad_reg, b_out_rd1); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI_6_5_1;
        tick();
        n_cmp++; if (a_out_valid !== 1'b1) begin n_err++;
            $display("FAIL rm_setup: got %0h want 1", a_out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_rd1 !== 32'd0 || a_stall_cnt !== 16'd0)
        begin n_err++;
            $display("FAIL rm_async: got v=%0h rd1=%0h st=%0d want 0 0 0",
                     a_out_valid, a_out_rd1, a_stall_cnt); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++;
            $display("FAIL rm_no_transfer: got %0h want 0", a_out_valid); end
        reset = 1'b0;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
            $display("FAIL rm_ready: got %0h want 1", a_in_ready); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd1 !== 32'd0 || b_out_rd1 !== 64'd0)
        begin n_err++;
            $display("FAIL rm_regs_cleared: got v=%0h %0h %0h want 1 0 0",
                     a_out_valid, a_out_rd1, b_out_rd1); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_use();
        test_bypass();
        test_backpressure_flush();
        test_imm_types();
        test_bad_reg_x0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
